// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between requesters A and B.
// Adds a DIVF macro op executed as invf(y) followed by mulf(x, 1/y).
module alu_arbiter #(
  parameter int unsigned        WIDTH  = 16,
  parameter int unsigned        OPW    = 5,
  parameter logic [OPW-1:0]     OPDIVF = 5'h10,
  parameter logic [OPW-1:0]     OPINVF = 5'h01,
  parameter logic [OPW-1:0]     OPMULF = 5'h03
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [OPW-1:0]   op_a,
  input  logic [WIDTH-1:0] in1_a,
  input  logic [WIDTH-1:0] in2_a,
  input  logic             req_b,
  input  logic [OPW-1:0]   op_b,
  input  logic [WIDTH-1:0] in1_b,
  input  logic [WIDTH-1:0] in2_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] result,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDiv2 = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  // owner/prio encoding: 0 = A, 1 = B
  logic [1:0]       state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             sel_b;
  logic             is_divf;

  assign is_divf = (op_q == OPDIVF);

  // On a tie the side that was not served last wins.
  assign sel_b = req_b & (~req_a | ~prio_q);

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    tmp_d    = tmp_q;
    result_d = result_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_a || req_b) begin
          owner_d = sel_b;
          op_d    = sel_b ? op_b  : op_a;
          x_d     = sel_b ? in1_b : in1_a;
          y_d     = sel_b ? in2_b : in2_a;
          gnt_a_d = ~sel_b;
          gnt_b_d = sel_b;
          state_d = StExec;
        end
      end
      StExec: begin
        tmp_d = alu_result;
        if (is_divf) begin
          state_d = StDiv2;
        end else begin
          result_d = alu_result;
          state_d  = StResp;
        end
      end
      StDiv2: begin
        result_d = alu_result;
        state_d  = StResp;
      end
      StResp: begin
        prio_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      prio_q   <= 1'b1;
      owner_q  <= 1'b0;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      tmp_q    <= '0;
      result_q <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tmp_q    <= tmp_d;
      result_q <= result_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
    end
  end

  // ALU bus is decoded purely from registered state.
  always_comb begin
    alu_op  = '0;
    alu_in1 = '0;
    alu_in2 = '0;
    case (state_q)
      StExec: begin
        alu_op  = is_divf ? OPINVF : op_q;
        alu_in1 = is_divf ? y_q : x_q;
        alu_in2 = y_q;
      end
      StDiv2: begin
        alu_op  = OPMULF;
        alu_in1 = x_q;
        alu_in2 = tmp_q;
      end
      default: ;
    endcase
  end

  assign gnt_a  = gnt_a_q;
  assign gnt_b  = gnt_b_q;
  assign done_a = (state_q == StResp) & ~owner_q;
  assign done_b = (state_q == StResp) & owner_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural stand-in ALU.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic [4:0]  op_a, op_b;
  logic [15:0] in1_a, in2_a, in1_b, in2_b;
  logic        gnt_a, gnt_b, done_a, done_b;
  logic [15:0] result;
  logic [4:0]  alu_op;
  logic [15:0] alu_in1, alu_in2, alu_result;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .op_a(op_a), .in1_a(in1_a), .in2_a(in2_a),
    .req_b(req_b), .op_b(op_b), .in1_b(in1_b), .in2_b(in2_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .result(result), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result)
  );

  // Stand-in ALU: invf/mulf are arbitrary but deterministic.
  function automatic logic [15:0] alu_fn(input logic [4:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      5'h00:   return a + b;
      5'h01:   return 16'h7800 - a;
      5'h03:   return (a ^ b) + 16'h0101;
      5'h06:   return a ^ b;
      5'h09:   return a >> 1;
      default: return a;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_op, alu_in1, alu_in2);

  function automatic logic [15:0] model(input logic [4:0] op, input logic [15:0] x,
                                        input logic [15:0] y);
    if (op == 5'h10) return alu_fn(5'h03, x, alu_fn(5'h01, y, y));
    return alu_fn(op, x, y);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (gnt_a || gnt_b) check("gnt_exclusive", {31'b0, gnt_a & gnt_b}, 0);
      if (done_a || done_b) check("done_exclusive", {31'b0, done_a & done_b}, 0);
      if (done_a) begin
        if (exp_a.size() == 0) check("done_a_unexpected", {31'b0, done_a}, 0);
        else check("result_a", {16'b0, result}, {16'b0, exp_a.pop_front()});
      end
      if (done_b) begin
        if (exp_b.size() == 0) check("done_b_unexpected", {31'b0, done_b}, 0);
        else check("result_b", {16'b0, result}, {16'b0, exp_b.pop_front()});
      end
    end
  end

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one request and return at the negedge of the grant cycle (state EXEC).
  task automatic issue(input bit side, input logic [4:0] op, input logic [15:0] x,
                       input logic [15:0] y, input bit push);
    bit seen = 0;
    if (push) begin
      if (side) exp_b.push_back(model(op, x, y));
      else exp_a.push_back(model(op, x, y));
    end
    if (side) begin req_b = 1; op_b = op; in1_b = x; in2_b = y; end
    else begin req_a = 1; op_a = op; in1_a = x; in2_a = y; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (side ? gnt_b : gnt_a) begin seen = 1; break; end
    end
    check(side ? "gnt_b_seen" : "gnt_a_seen", {31'b0, seen}, 1);
    req_a = 0;
    req_b = 0;
  endtask

  // Both sides held: A add 1+1, B xor; grants must alternate starting with 'first'.
  task automatic run_both(input int n, input bit first);
    int k = 0;
    req_a = 1; op_a = 5'h00; in1_a = 16'h0001; in2_a = 16'h0001;
    req_b = 1; op_b = 5'h06; in1_b = 16'h00FF; in2_b = 16'h0F0F;
    for (int i = 0; i < n / 2; i++) begin
      exp_a.push_back(16'h0002);
      exp_b.push_back(16'h0FF0);
    end
    for (int i = 0; i < 10 * n; i++) begin
      @(negedge clk);
      if (gnt_a || gnt_b) begin
        check("gnt_order", {31'b0, gnt_b}, {31'b0, first ^ k[0]});
        k++;
        if (k == n) break;
      end
    end
    check("grant_count", k, n);
    req_a = 0;
    req_b = 0;
    settle(3);
  endtask

  initial begin
    logic [15:0] inv;
    reset = 1;
    req_a = 0; op_a = 0; in1_a = 0; in2_a = 0;
    req_b = 0; op_b = 0; in1_b = 0; in2_b = 0;

    // Reset with req_a held, then first edge after release grants A.
    @(negedge clk);
    req_a = 1; op_a = 5'h00; in1_a = 16'h0003; in2_a = 16'h0004;
    exp_a.push_back(16'h0007);
    @(negedge clk);
    check("rst_gnt_a", {31'b0, gnt_a}, 0);
    check("rst_gnt_b", {31'b0, gnt_b}, 0);
    check("rst_done_a", {31'b0, done_a}, 0);
    check("rst_done_b", {31'b0, done_b}, 0);
    check("rst_result", {16'b0, result}, 0);
    check("rst_alu_op", {27'b0, alu_op}, 0);
    check("rst_alu_in1", {16'b0, alu_in1}, 0);
    check("rst_alu_in2", {16'b0, alu_in2}, 0);
    reset = 0;
    @(negedge clk);
    check("t1_gnt_a", {31'b0, gnt_a}, 1);
    check("t1_alu_op", {27'b0, alu_op}, 0);
    check("t1_alu_in1", {16'b0, alu_in1}, 3);
    check("t1_alu_in2", {16'b0, alu_in2}, 4);
    req_a = 0;
    @(negedge clk);
    check("t1_done_a", {31'b0, done_a}, 1);
    check("t1_done_b", {31'b0, done_b}, 0);
    settle(1);

    issue(0, 5'h00, 16'h1111, 16'h2222, 1);
    check("add_alu_in1", {16'b0, alu_in1}, 16'h1111);
    settle(2);

    // Undefined op forwarded unchanged.
    issue(0, 5'h0F, 16'h1234, 16'h5555, 1);
    check("undef_alu_op", {27'b0, alu_op}, 5'h0F);
    settle(2);

    // B shift right; leaves prio at B so the tie run starts with A.
    issue(1, 5'h09, 16'h8002, 16'h0000, 1);
    check("shr_alu_op", {27'b0, alu_op}, 5'h09);
    settle(2);

    run_both(4, 0);

    // DIVF from A: two ALU passes, done at +3.
    issue(0, 5'h10, 16'h4000, 16'h4000, 1);
    inv = alu_fn(5'h01, 16'h4000, 16'h4000);
    check("divf_exec_op", {27'b0, alu_op}, 5'h01);
    check("divf_exec_in1", {16'b0, alu_in1}, 16'h4000);
    check("divf_exec_in2", {16'b0, alu_in2}, 16'h4000);
    @(negedge clk);
    check("divf_div2_op", {27'b0, alu_op}, 5'h03);
    check("divf_div2_in1", {16'b0, alu_in1}, 16'h4000);
    check("divf_div2_in2", {16'b0, alu_in2}, {16'b0, inv});
    check("divf_early_done", {31'b0, done_a}, 0);
    @(negedge clk);
    check("divf_done_a", {31'b0, done_a}, 1);
    settle(1);

    // Reset in DIV2 of a B DIVF: dropped, no done_b, prio back to B.
    issue(1, 5'h10, 16'h3C00, 16'h4400, 0);
    @(negedge clk);
    check("div2_reached_op", {27'b0, alu_op}, 5'h03);
    reset = 1;
    @(negedge clk);
    check("mid_rst_done_b", {31'b0, done_b}, 0);
    check("mid_rst_result", {16'b0, result}, 0);
    check("mid_rst_alu_op", {27'b0, alu_op}, 0);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_b_after_rst", {31'b0, done_b}, 0);
    end
    run_both(2, 0);
    issue(0, 5'h00, 16'h0005, 16'h0006, 1);
    settle(3);

    check("exp_a_drained", exp_a.size(), 0);
    check("exp_b_drained", exp_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
